red_pitaya_dfilt2: RTL

RED_PITAYA_DFILT2 -- requirements
Module: red_pitaya_dfilt2

---
 rtl/red_pitaya_dfilt2.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_dfilt2.sv
// Six-stage fixed-point cascade (FIR, two IIR sections, scaler with saturation)
// with staged/active coefficient sets, bypass and a saturating overflow counter.
module red_pitaya_dfilt2 #(
  parameter int IW = 14,
  parameter int OW = 12,
  parameter int CW = 16
) (
  input  logic                 adc_clk_i,
  input  logic                 adc_rstn_i,
  input  logic signed [IW-1:0] adc_dat_i,
  input  logic                 adc_vld_i,
  output logic signed [OW-1:0] adc_dat_o,
  output logic                 adc_vld_o,
  input  logic signed [17:0]   cfg_aa_i,
  input  logic signed [24:0]   cfg_bb_i,
  input  logic signed [24:0]   cfg_kk_i,
  input  logic signed [24:0]   cfg_pp_i,
  input  logic                 cfg_upd_i,
  input  logic                 cfg_clr_i,
  input  logic                 cfg_byp_i,
  output logic                 sat_o,
  output logic [CW-1:0]        sat_cnt_o,
  input  logic                 sat_clr_i
);

  logic signed [17:0]   aa_q, aa_d;
  logic signed [24:0]   bb_q, bb_d, kk_q, kk_d, pp_q, pp_d;
  logic                 byp_q, byp_d;
  logic [5:0]           vld_q, vld_d;
  logic signed [13:0]   x_q, x_d, xd_q, xd_d;
  logic signed [13:0]   xb2_q, xb2_d, xb3_q, xb3_d, xb4_q, xb4_d, xb5_q, xb5_d;
  logic signed [22:0]   s1_q, s1_d, s2_q, s2_d;
  logic signed [14:0]   u_q, u_d, s3_q, s3_d;
  logic signed [15:0]   m_q, m_d;
  logic signed [OW-1:0] dat_q, dat_d;
  logic                 sat_q, sat_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic signed [13:0]   x_in;
  logic signed [38:0]   fir_prod;
  logic signed [39:0]   fir_sum;
  logic signed [40:0]   aa_prod;
  logic signed [48:0]   iir1_t;
  logic signed [39:0]   pp_prod, iir2_sum, kk_prod;
  logic signed [22:0]   s1_new, s2_new;
  logic signed [14:0]   u_new, s3_new;
  logic signed [15:0]   m_new;
  logic signed [13:0]   y_clamp;
  logic signed [OW-1:0] out_dat;
  logic                 out_sat, out_fire;

  // Datapath arithmetic; every stage reads only registered values and active coefficients.
  always_comb begin
    x_in     = 14'(adc_dat_i) <<< (14 - IW);
    fir_prod = 39'(bb_q) * 39'(xd_q);
    fir_sum  = (40'(x_q) <<< 18) + (40'(fir_prod) >>> 10) - (40'(xd_q) <<< 18);
    s1_new   = 23'(fir_sum >>> 10);
    aa_prod  = 41'(aa_q) * 41'(s2_q);
    iir1_t   = (49'(s1_q) <<< 25) + (49'(s2_q) <<< 25) - 49'(aa_prod);
    s2_new   = 23'(iir1_t >>> 25);
    u_new    = 15'(iir1_t >>> 33);
    pp_prod  = 40'(pp_q) * 40'(s3_q);
    iir2_sum = 40'(u_q) + (pp_prod >>> 16);
    s3_new   = 15'(iir2_sum);
    kk_prod  = 40'(kk_q) * 40'(s3_q);
    m_new    = 16'(kk_prod >>> 24);

    y_clamp = 14'(m_q);
    out_sat = 1'b0;
    if (m_q > 16'sd8191) begin
      y_clamp = 14'sd8191;
      out_sat = 1'b1;
    end else if (m_q < 16'shE000) begin
      y_clamp = 14'sh2000;
      out_sat = 1'b1;
    end
    out_dat = OW'(y_clamp >>> (14 - OW));
    if (byp_q) begin
      out_dat = OW'(xb5_q >>> (14 - OW));
      out_sat = 1'b0;
    end
    out_fire = vld_q[4] && !cfg_clr_i;
  end

  // A clear drops in-flight samples and recursive state but keeps the active coefficients.
  always_comb begin
    aa_d  = aa_q;
    bb_d  = bb_q;
    kk_d  = kk_q;
    pp_d  = pp_q;
    byp_d = byp_q;
    vld_d = {vld_q[4:0], adc_vld_i};
    x_d   = x_q;
    xd_d  = xd_q;
    xb2_d = xb2_q;
    xb3_d = xb3_q;
    xb4_d = xb4_q;
    xb5_d = xb5_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    u_d   = u_q;
    s3_d  = s3_q;
    m_d   = m_q;
    dat_d = dat_q;
    sat_d = sat_q;
    cnt_d = cnt_q;

    if (cfg_upd_i) begin
      aa_d  = cfg_aa_i;
      bb_d  = cfg_bb_i;
      kk_d  = cfg_kk_i;
      pp_d  = cfg_pp_i;
      byp_d = cfg_byp_i;
    end
    if (adc_vld_i) x_d = x_in;
    if (vld_q[0]) begin
      s1_d  = s1_new;
      xd_d  = x_q;
      xb2_d = x_q;
    end
    if (vld_q[1]) begin
      s2_d  = s2_new;
      u_d   = u_new;
      xb3_d = xb2_q;
    end
    if (vld_q[2]) begin
      s3_d  = s3_new;
      xb4_d = xb3_q;
    end
    if (vld_q[3]) begin
      m_d   = m_new;
      xb5_d = xb4_q;
    end
    if (out_fire) begin
      dat_d = out_dat;
      sat_d = out_sat;
    end
    if (sat_clr_i) begin
      cnt_d = '0;
    end else if (out_fire && out_sat && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cfg_clr_i) begin
      vld_d = '0;
      xd_d  = '0;
      s2_d  = '0;
      s3_d  = '0;
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      aa_q  <= '0;
      bb_q  <= '0;
      kk_q  <= '0;
      pp_q  <= '0;
      byp_q <= 1'b0;
      vld_q <= '0;
      x_q   <= '0;
      xd_q  <= '0;
      xb2_q <= '0;
      xb3_q <= '0;
      xb4_q <= '0;
      xb5_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      u_q   <= '0;
      s3_q  <= '0;
      m_q   <= '0;
      dat_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      aa_q  <= aa_d;
      bb_q  <= bb_d;
      kk_q  <= kk_d;
      pp_q  <= pp_d;
      byp_q <= byp_d;
      vld_q <= vld_d;
      x_q   <= x_d;
      xd_q  <= xd_d;
      xb2_q <= xb2_d;
      xb3_q <= xb3_d;
      xb4_q <= xb4_d;
      xb5_q <= xb5_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      u_q   <= u_d;
      s3_q  <= s3_d;
      m_q   <= m_d;
      dat_q <= dat_d;
      sat_q <= sat_d;
      cnt_q <= cnt_d;
    end
  end

  assign adc_dat_o = dat_q;
  assign adc_vld_o = vld_q[5];
  assign sat_o     = sat_q;
  assign sat_cnt_o = cnt_q;

endmodule
